// File: rtl/pong_engine_if.sv
// Signal bundle between the pong engine and its video/controller surroundings.
interface pong_engine_if #(
  parameter int SCORE_W = 4
);
  logic               video_on;
  logic [9:0]         x;
  logic [9:0]         y;
  logic               p1_up;
  logic               p1_down;
  logic               p2_up;
  logic               p2_down;
  logic               serve;
  logic [11:0]        rgb;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic               game_over;
  logic               frame_tick;

  modport master (
    output video_on, x, y, p1_up, p1_down, p2_up, p2_down, serve,
    input  rgb, p1_score, p2_score, game_over, frame_tick
  );

  modport slave (
    input  video_on, x, y, p1_up, p1_down, p2_up, p2_down, serve,
    output rgb, p1_score, p2_score, game_over, frame_tick
  );
endinterface

// File: rtl/pong_engine.sv
// Two-player pong: paddles, ball, scoring FSM and pixel colour, all advanced
// once per frame on the strobe that fires just below the visible area.
module pong_engine #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int PADDLE_H   = 98,
  parameter int PADDLE_W   = 5,
  parameter int BALL_SIZE  = 12,
  parameter int PADDLE_V   = 2,
  parameter int BALL_V     = 3,
  parameter int WIN_SCORE  = 7,
  parameter int SCORE_W    = 4,
  parameter int POINT_WAIT = 60
) (
  input  logic         clk,
  input  logic         reset,
  pong_engine_if.slave bus
);
  localparam logic [10:0] P1_L = 11'd16;
  localparam logic [10:0] P1_R = 11'(16 + PADDLE_W - 1);
  localparam logic [10:0] P2_L = 11'(H_ACTIVE - 16 - PADDLE_W);
  localparam logic [10:0] P2_R = 11'(H_ACTIVE - 17);
  localparam logic [10:0] HA   = 11'(H_ACTIVE);
  localparam logic [10:0] VA   = 11'(V_ACTIVE);
  localparam logic [10:0] BS   = 11'(BALL_SIZE);
  localparam logic [10:0] BV   = 11'(BALL_V);
  localparam logic [10:0] PH   = 11'(PADDLE_H);
  localparam logic [10:0] PV   = 11'(PADDLE_V);
  localparam logic [9:0]  BALL_X0 = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]  BALL_Y0 = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]  PAD_Y0  = 10'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  localparam int CNT_W = $clog2(POINT_WAIT + 1);

  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, OVER} state_t;

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [9:0]         ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic               dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic        tick_w;
  logic [10:0] x_w, y_w, bx_w, by_w;
  logic [1:0]  up_w, down_w, pad_on_w;
  logic [10:0] top_w [2];

  assign tick_w = (bus.y == 10'(V_ACTIVE + 1)) && (bus.x == 10'd0);
  assign x_w    = {1'b0, bus.x};
  assign y_w    = {1'b0, bus.y};
  assign bx_w   = {1'b0, ball_x_q};
  assign by_w   = {1'b0, ball_y_q};
  assign up_w   = {bus.p2_up, bus.p1_up};
  assign down_w = {bus.p2_down, bus.p1_down};

  for (genvar gi = 0; gi < 2; gi++) begin : g_pad
    localparam logic [10:0] COL_L = (gi == 0) ? P1_L : P2_L;
    localparam logic [10:0] COL_R = (gi == 0) ? P1_R : P2_R;
    logic [9:0] top_q, top_d;

    // Moving up is refused once the top would drop to PADDLE_V or below.
    always_comb begin
      top_d = top_q;
      if (tick_w && state_q != OVER) begin
        if (up_w[gi] && !down_w[gi] && top_w[gi] > PV + PV)
          top_d = top_q - 10'(PADDLE_V);
        else if (down_w[gi] && !up_w[gi] && top_w[gi] + PH - 11'd1 < VA - 11'd1 - PV)
          top_d = top_q + 10'(PADDLE_V);
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) top_q <= PAD_Y0;
      else        top_q <= top_d;
    end

    assign top_w[gi]    = {1'b0, top_q};
    assign pad_on_w[gi] = (x_w >= COL_L) && (x_w <= COL_R) &&
                          (y_w >= top_w[gi]) && (y_w < top_w[gi] + PH);
  end

  logic ov1_w, ov2_w, hit1_w, hit2_w, score1_w, score2_w, scoring_w;
  assign ov1_w     = (by_w + BS > top_w[0]) && (by_w < top_w[0] + PH);
  assign ov2_w     = (by_w + BS > top_w[1]) && (by_w < top_w[1] + PH);
  assign hit1_w    = !dir_x_q && (bx_w <= P1_R + BV) && ov1_w;
  assign hit2_w    = dir_x_q && (bx_w + BV + BS - 11'd1 >= P2_L) && ov2_w;
  assign score2_w  = !dir_x_q && (bx_w < BV);
  assign score1_w  = dir_x_q && (bx_w + BS - 11'd1 > HA - 11'd1 - BV);
  assign scoring_w = (score1_w || score2_w) && !hit1_w && !hit2_w;

  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    cnt_d    = cnt_q;
    if (tick_w) begin
      case (state_q)
        IDLE: if (bus.serve) begin
          state_d  = SERVE;
          ball_x_d = BALL_X0;
          ball_y_d = BALL_Y0;
        end
        SERVE: begin
          ball_x_d = BALL_X0;
          ball_y_d = BALL_Y0;
          if (bus.serve) state_d = PLAY;
        end
        PLAY: begin
          if (hit1_w) begin
            ball_x_d = 10'(P1_R + 11'd1);
            dir_x_d  = 1'b1;
          end else if (hit2_w) begin
            ball_x_d = 10'(P2_L - BS);
            dir_x_d  = 1'b0;
          end else if (scoring_w) begin
            // Serve direction points at whoever just conceded.
            state_d = POINT;
            cnt_d   = '0;
            if (score1_w) begin
              p1_d    = (p1_q == WIN) ? p1_q : p1_q + SCORE_W'(1);
              dir_x_d = 1'b1;
            end else begin
              p2_d    = (p2_q == WIN) ? p2_q : p2_q + SCORE_W'(1);
              dir_x_d = 1'b0;
            end
          end else if (dir_x_q) begin
            ball_x_d = ball_x_q + 10'(BALL_V);
          end else begin
            ball_x_d = ball_x_q - 10'(BALL_V);
          end
          if (!scoring_w) begin
            if (!dir_y_q && by_w < BV) begin
              ball_y_d = 10'd0;
              dir_y_d  = 1'b1;
            end else if (dir_y_q && by_w + BS - 11'd1 > VA - 11'd1 - BV) begin
              ball_y_d = 10'(VA - BS);
              dir_y_d  = 1'b0;
            end else if (dir_y_q) begin
              ball_y_d = ball_y_q + 10'(BALL_V);
            end else begin
              ball_y_d = ball_y_q - 10'(BALL_V);
            end
          end
        end
        POINT: begin
          if (cnt_q == CNT_W'(POINT_WAIT - 1)) begin
            cnt_d = '0;
            if (p1_q == WIN || p2_q == WIN) begin
              state_d = OVER;
            end else begin
              state_d  = SERVE;
              ball_x_d = BALL_X0;
              ball_y_d = BALL_Y0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        OVER: if (bus.serve) begin
          state_d  = SERVE;
          p1_d     = '0;
          p2_d     = '0;
          ball_x_d = BALL_X0;
          ball_y_d = BALL_Y0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      p1_q     <= '0;
      p2_q     <= '0;
      ball_x_q <= BALL_X0;
      ball_y_q <= BALL_Y0;
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      cnt_q    <= cnt_d;
    end
  end

  logic ball_on_w, centre_on_w;
  assign ball_on_w = (state_q == SERVE || state_q == PLAY || state_q == POINT) &&
                     (x_w >= bx_w) && (x_w < bx_w + BS) &&
                     (y_w >= by_w) && (y_w < by_w + BS);
  assign centre_on_w = (bus.x == 10'(H_ACTIVE / 2)) && !bus.y[3];

  always_comb begin
    bus.rgb = 12'hCCC;
    if (!bus.video_on)   bus.rgb = 12'h000;
    else if (ball_on_w)  bus.rgb = 12'h0FF;
    else if (|pad_on_w)  bus.rgb = 12'h111;
    else if (centre_on_w) bus.rgb = 12'h888;
  end

  assign bus.frame_tick = tick_w;
  assign bus.p1_score   = p1_q;
  assign bus.p2_score   = p2_q;
  assign bus.game_over  = (state_q == OVER);
endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine: raster vector table plus hand-traced rallies.
module tb_pong_engine;
  localparam int V_ACTIVE = 480;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pong_engine_if #(.SCORE_W(4)) bus ();

  pong_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       vo;
    logic [9:0] x;
    logic [9:0] y;
    logic [11:0] rgb;
    logic       ft;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    @(negedge clk);
    bus.x = 10'd0;
    bus.y = 10'(V_ACTIVE + 1);
    repeat (n) @(posedge clk);
    @(negedge clk);
    bus.x = 10'd1;
  endtask

  task automatic pix(input int px, input int py, output logic [11:0] c);
    @(negedge clk);
    bus.video_on = 1'b1;
    bus.x = 10'(px);
    bus.y = 10'(py);
    #1 c = bus.rgb;
  endtask

  task automatic check_pix(input string name, input int px, input int py, input logic [11:0] exp);
    logic [11:0] c;
    pix(px, py, c);
    check(name, {20'd0, c}, {20'd0, exp});
  endtask

  task automatic check_ball(input string name, input int bx, input int by);
    logic [11:0] c0, c1, c2;
    pix(bx, by, c0);
    pix(bx - 1, by, c1);
    pix(bx, by - 1, c2);
    checks++;
    if (c0 !== 12'h0FF || c1 === 12'h0FF || c2 === 12'h0FF) begin
      errors++;
      $display("FAIL %s: at (%0d,%0d) rgb=%h left=%h above=%h, expected ball origin (0ff, neighbours not 0ff)",
               name, bx, by, c0, c1, c2);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.p1_up = 1'b0; bus.p1_down = 1'b0;
    bus.p2_up = 1'b0; bus.p2_down = 1'b0;
    bus.serve = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bus.video_on = 1'b0;
    bus.x = 10'd1;
    bus.y = 10'd0;
    bus.p1_up = 1'b0; bus.p1_down = 1'b0;
    bus.p2_up = 1'b0; bus.p2_down = 1'b0;
    bus.serve = 1'b0;

    vecs[0]  = '{1'b1, 10'd16,  10'd191, 12'h111, 1'b0};
    vecs[1]  = '{1'b1, 10'd16,  10'd190, 12'hCCC, 1'b0};
    vecs[2]  = '{1'b1, 10'd20,  10'd288, 12'h111, 1'b0};
    vecs[3]  = '{1'b1, 10'd21,  10'd288, 12'hCCC, 1'b0};
    vecs[4]  = '{1'b1, 10'd16,  10'd289, 12'hCCC, 1'b0};
    vecs[5]  = '{1'b1, 10'd619, 10'd191, 12'h111, 1'b0};
    vecs[6]  = '{1'b1, 10'd623, 10'd288, 12'h111, 1'b0};
    vecs[7]  = '{1'b1, 10'd624, 10'd200, 12'hCCC, 1'b0};
    vecs[8]  = '{1'b1, 10'd618, 10'd200, 12'hCCC, 1'b0};
    vecs[9]  = '{1'b1, 10'd320, 10'd0,   12'h888, 1'b0};
    vecs[10] = '{1'b1, 10'd320, 10'd8,   12'hCCC, 1'b0};
    vecs[11] = '{1'b1, 10'd320, 10'd16,  12'h888, 1'b0};
    vecs[12] = '{1'b1, 10'd314, 10'd234, 12'hCCC, 1'b0};
    vecs[13] = '{1'b0, 10'd16,  10'd191, 12'h000, 1'b0};
    vecs[14] = '{1'b0, 10'd1,   10'd481, 12'h000, 1'b0};
    vecs[15] = '{1'b0, 10'd0,   10'd480, 12'h000, 1'b0};
    vecs[16] = '{1'b0, 10'd0,   10'd481, 12'h000, 1'b1};

    repeat (3) @(posedge clk);
    do_reset();

    // Reset state and raster table (IDLE: no ball drawn, controls idle).
    check("reset game_over", {31'd0, bus.game_over}, 32'd0);
    check("reset p1_score", {28'd0, bus.p1_score}, 32'd0);
    check("reset p2_score", {28'd0, bus.p2_score}, 32'd0);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bus.video_on = vecs[i].vo;
      bus.x = vecs[i].x;
      bus.y = vecs[i].y;
      #1;
      check($sformatf("vec%0d rgb", i), {20'd0, bus.rgb}, {20'd0, vecs[i].rgb});
      check($sformatf("vec%0d frame_tick", i), {31'd0, bus.frame_tick}, {31'd0, vecs[i].ft});
    end
    @(negedge clk);
    bus.x = 10'd1;
    bus.y = 10'd0;

    // Paddle limits; nothing moves on cycles without a frame tick.
    bus.p1_up = 1'b1;
    repeat (5) @(posedge clk);
    check_pix("p1 no move off-tick", 16, 190, 12'hCCC);
    tick(100);
    check_pix("p1 top stops at 3", 16, 3, 12'h111);
    check_pix("p1 not above 3", 16, 2, 12'hCCC);
    bus.p1_down = 1'b1;
    tick(5);
    check_pix("p1 up+down top", 16, 2, 12'hCCC);
    check_pix("p1 up+down bottom", 16, 101, 12'hCCC);
    check_pix("p1 up+down hold", 16, 3, 12'h111);
    bus.p1_up = 1'b0; bus.p1_down = 1'b0;
    bus.p2_down = 1'b1;
    tick(100);
    bus.p2_down = 1'b0;
    check_pix("p2 top at 381", 619, 381, 12'h111);
    check_pix("p2 above 381 clear", 619, 380, 12'hCCC);
    check_pix("p2 bottom 478", 619, 478, 12'h111);

    // Serve sequence and first PLAY move.
    bus.serve = 1'b1;
    tick(1);
    check_ball("serve centred", 314, 234);
    check_pix("ball over centre line", 320, 240, 12'h0FF);
    tick(1);
    bus.serve = 1'b0;
    check_ball("play start still centred", 314, 234);
    tick(1);
    check_ball("first play move", 317, 237);
    tick(96);
    check_ball("before p2 hit", 605, 414);
    tick(1);
    check_ball("p2 hit clamp", 607, 411);
    tick(202);
    check_ball("ball passes p1", 1, 192);
    check("p2_score before point", {28'd0, bus.p2_score}, 32'd0);
    tick(1);
    check("p2 scores", {28'd0, bus.p2_score}, 32'd1);
    check("p1 unchanged", {28'd0, bus.p1_score}, 32'd0);
    tick(59);
    check_ball("point hold 59", 1, 192);
    tick(1);
    check_ball("serve after point", 314, 234);
    check("p2_score kept", {28'd0, bus.p2_score}, 32'd1);
    bus.serve = 1'b1;
    tick(1);
    bus.serve = 1'b0;
    tick(1);
    check_ball("serve heads left", 311, 237);
    tick(2);
    check_ball("mid rally", 305, 243);

    // Reset mid-rally aborts to the power-up values.
    do_reset();
    check("mid reset p2_score", {28'd0, bus.p2_score}, 32'd0);
    check("mid reset game_over", {31'd0, bus.game_over}, 32'd0);
    check_pix("mid reset no ball", 305, 243, 12'hCCC);
    check_pix("mid reset p1 top", 16, 191, 12'h111);
    check_pix("mid reset p2 top", 619, 191, 12'h111);

    // P1 paddle return: ball meets P1 at top 171.
    bus.p1_up = 1'b1;
    tick(10);
    bus.p1_up = 1'b0;
    bus.p2_down = 1'b1;
    tick(100);
    bus.p2_down = 1'b0;
    bus.serve = 1'b1;
    tick(2);
    bus.serve = 1'b0;
    tick(293);
    check_ball("approach p1", 22, 171);
    tick(1);
    check_ball("p1 hit clamp", 21, 174);
    check("p1 hit no score", {28'd0, bus.p2_score}, 32'd0);
    tick(1);
    check_ball("after p1 hit heads right", 24, 177);

    // Full game to OVER with P1 winning every rally.
    do_reset();
    bus.serve = 1'b1;
    tick(1);
    for (int r = 1; r <= 7; r++) begin
      bus.serve = 1'b1;
      tick(1);
      bus.serve = 1'b0;
      tick(104);
      check($sformatf("rally%0d pre score", r), {28'd0, bus.p1_score}, 32'(r - 1));
      tick(1);
      check($sformatf("rally%0d p1_score", r), {28'd0, bus.p1_score}, 32'(r));
      check($sformatf("rally%0d p2_score", r), {28'd0, bus.p2_score}, 32'd0);
      tick(59);
      check($sformatf("rally%0d point game_over", r), {31'd0, bus.game_over}, 32'd0);
      tick(1);
      check($sformatf("rally%0d after point game_over", r), {31'd0, bus.game_over}, (r == 7) ? 32'd1 : 32'd0);
    end
    bus.p1_up = 1'b1;
    tick(5);
    bus.p1_up = 1'b0;
    check("over holds", {31'd0, bus.game_over}, 32'd1);
    check_pix("over paddle frozen", 16, 190, 12'hCCC);
    check_pix("over paddle top", 16, 191, 12'h111);
    check_pix("over no ball", 626, 393, 12'hCCC);
    bus.serve = 1'b1;
    tick(1);
    bus.serve = 1'b0;
    check("new game game_over", {31'd0, bus.game_over}, 32'd0);
    check("new game p1_score", {28'd0, bus.p1_score}, 32'd0);
    check("new game p2_score", {28'd0, bus.p2_score}, 32'd0);
    check_ball("new game centred", 314, 234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
